// File: rtl/control_loader_if.sv
// Handshake and combiner-port bundle for control_loader.
// slave: the loader side. master: host/upstream/combiner side.
interface control_loader_if;
  logic        start;
  logic [5:0]  start_addr;
  logic [6:0]  count;
  logic        abort;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] signal;
  logic [5:0]  blockaddress;
  logic        write;
  logic        busy;
  logic        done;
  logic [63:0] slot_loaded;

  modport slave (
    input  start, start_addr, count, abort, clear, in_data, in_valid,
    output in_ready, signal, blockaddress, write, busy, done, slot_loaded
  );

  modport master (
    output start, start_addr, count, abort, clear, in_data, in_valid,
    input  in_ready, signal, blockaddress, write, busy, done, slot_loaded
  );
endinterface

// File: rtl/control_loader.sv
// Burst sequencer loading 16-bit control words into the 64-slot combiner.
// One word per accepted upstream transfer, written one cycle later; tracks
// which slots have been written since the last clear/reset.
module control_loader (
  input  logic           clk,
  input  logic           reset,
  control_loader_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [6:0]  remaining_q, remaining_d;
  logic [15:0] signal_q, signal_d;
  logic [5:0]  blockaddress_q, blockaddress_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic [63:0] slot_loaded_q, slot_loaded_d;

  logic        in_ready;
  logic        accept;
  logic [6:0]  count_clamped;

  // Ready depends only on state and abort, never on in_valid.
  assign in_ready      = (state_q == LOAD) & ~bus.abort;
  assign accept        = bus.in_valid & in_ready;
  assign count_clamped = (bus.count > 7'd64) ? 7'd64 : bus.count;

  // Burst sequencing: latch request in IDLE, emit one write per accept in LOAD.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    signal_d       = signal_q;
    blockaddress_d = blockaddress_q;
    write_d        = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d      = bus.start_addr;
          remaining_d = count_clamped;
          if (count_clamped == 7'd0) done_d  = 1'b1;
          else                       state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (accept) begin
          signal_d       = bus.in_data;
          blockaddress_d = addr_q;
          write_d        = 1'b1;
          addr_d         = addr_q + 6'd1;
          remaining_d    = remaining_q - 7'd1;
          if (remaining_q == 7'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loaded-slot mask: clear wins over history but not over a write in the same cycle.
  always_comb begin
    slot_loaded_d = bus.clear ? '0 : slot_loaded_q;
    if (write_q) slot_loaded_d[blockaddress_q] = 1'b1;
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      signal_q       <= '0;
      blockaddress_q <= '0;
      write_q        <= 1'b0;
      done_q         <= 1'b0;
      slot_loaded_q  <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      signal_q       <= signal_d;
      blockaddress_q <= blockaddress_d;
      write_q        <= write_d;
      done_q         <= done_d;
      slot_loaded_q  <= slot_loaded_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.signal       = signal_q;
  assign bus.blockaddress = blockaddress_q;
  assign bus.write        = write_q;
  assign bus.busy         = (state_q == LOAD);
  assign bus.done         = done_q;
  assign bus.slot_loaded  = slot_loaded_q;

endmodule

// File: tb/tb_control_loader.sv
// Self-checking bench for control_loader: directed and randomized bursts
// against a burst-level reference model (expected word list per burst,
// expected slot mask, last-driven combiner word/slot).
module tb_control_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_loader_if bus();

  control_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [63:0] mask_m;
  bit          pend_w;
  logic [5:0]  pend_slot;
  logic [15:0] last_sig;
  logic [5:0]  last_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s bound expired", tag);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called once per cycle, #1 after the edge. bus.clear still holds the value
  // driven during the cycle that just ended.
  task automatic check_cycle(input bit w, input logic [15:0] s, input logic [5:0] ad,
                             input bit dn, input bit bz);
    if (bus.clear) mask_m = pend_w ? (64'd1 << pend_slot) : 64'd0;
    else if (pend_w) mask_m[pend_slot] = 1'b1;
    if (w) begin
      last_sig  = s;
      last_addr = ad;
    end
    chk("write",        64'(bus.write),        64'(w));
    chk("signal",       64'(bus.signal),       64'(last_sig));
    chk("blockaddress", 64'(bus.blockaddress), 64'(last_addr));
    chk("done",         64'(bus.done),         64'(dn));
    chk("busy",         64'(bus.busy),         64'(bz));
    chk("slot_loaded",  bus.slot_loaded,       mask_m);
    pend_w    = w;
    pend_slot = ad;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"},     64'(bus.in_ready),     64'd0);
    chk({tag, "_signal"},       64'(bus.signal),       64'd0);
    chk({tag, "_blockaddress"}, 64'(bus.blockaddress), 64'd0);
    chk({tag, "_write"},        64'(bus.write),        64'd0);
    chk({tag, "_busy"},         64'(bus.busy),         64'd0);
    chk({tag, "_done"},         64'(bus.done),         64'd0);
    chk({tag, "_slot_loaded"},  bus.slot_loaded,       64'd0);
  endtask

  task automatic model_reset();
    mask_m    = '0;
    pend_w    = 1'b0;
    pend_slot = '0;
    last_sig  = '0;
    last_addr = '0;
  endtask

  task automatic midreset();
    bus.in_valid = 1'b1;
    #2 reset = 1'b1;
    #1 check_all_zero("midrst");
    bus.start      = 1'b1;
    bus.start_addr = 6'd9;
    bus.count      = 7'd5;
    repeat (3) begin
      cyc();
      chk("rst_busy",  64'(bus.busy),  64'd0);
      chk("rst_write", 64'(bus.write), 64'd0);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    bus.clear    = 1'b0;
    reset        = 1'b0;
    model_reset();
    cyc();
    check_cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc();
    check_cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // One burst: expected writes are word k to slot (a+k) mod 64, k < min(c,64).
  // Starts at a checkpoint in IDLE; returns at the checkpoint where busy has fallen.
  task automatic burst(input logic [5:0] a, input int c, input bit ramp, input int gap,
                       input int abort_after, input int rst_after, input int clr_at);
    logic [15:0] d[64];
    int n, idx, pend, budget;
    bit ab;
    n = (c > 64) ? 64 : c;
    idx = 0; pend = -1; budget = 0; ab = 1'b0;
    for (int i = 0; i < 64; i++) d[i] = ramp ? 16'(i * 4) : 16'($urandom);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.count      = 7'(c);
    if (n == 0) begin
      cyc();
      bus.start = 1'b0;
      check_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      return;
    end
    forever begin
      cyc();
      check_cycle(pend >= 0, (pend >= 0) ? d[pend] : 16'h0, a + 6'(pend),
                  (pend == n - 1), !(ab || idx == n));
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.clear = (pend >= 0 && pend == clr_at);
      if (ab || idx == n) begin
        chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
        break;
      end
      if (++budget > 400) begin
        fail_now("burst_budget");
        break;
      end
      if (idx == rst_after) begin
        midreset();
        return;
      end
      bus.start      = 1'($urandom_range(0, 1));
      bus.start_addr = 6'($urandom);
      bus.count      = 7'($urandom);
      bus.abort      = (idx == abort_after);
      bus.in_valid   = bus.abort || gap == 0 || (int'($urandom_range(0, 99)) >= gap);
      bus.in_data    = bus.in_valid ? d[idx] : 16'($urandom);
      #1 chk("in_ready", 64'(bus.in_ready), 64'(!bus.abort));
      if (bus.abort) begin
        ab   = 1'b1;
        pend = -1;
      end else if (bus.in_valid) begin
        pend = idx;
        idx++;
      end else begin
        pend = -1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.start_addr = '0; bus.count = '0; bus.abort = 1'b0;
    bus.clear = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0;
    model_reset();
    reset = 1'b1;
    repeat (2) cyc();
    check_all_zero("reset");
    reset = 1'b0;
    idle();

    // Full 64-word ramp from slot 0.
    burst(6'd0, 64, 1'b1, 0, -1, -1, -1);
    idle();
    chk("mask_all_ones", bus.slot_loaded, {64{1'b1}});

    // Clear, then wrap-around burst 62,63,0,1.
    bus.clear = 1'b1;
    idle();
    bus.clear = 1'b0;
    burst(6'd62, 4, 1'b0, 0, -1, -1, -1);
    idle();
    chk("mask_wrap", bus.slot_loaded, 64'hC000_0000_0000_0003);

    // Valid gaps stall without losing words.
    burst(6'd10, 3, 1'b0, 50, -1, -1, -1);
    // Abort after 3 accepts, new burst immediately after.
    burst(6'd20, 8, 1'b0, 0, 3, -1, -1);
    burst(6'd30, 5, 1'b0, 30, -1, -1, -1);
    // count==0 then clamped 100 -> 64 words from slot 5.
    burst(6'd40, 0, 1'b0, 0, -1, -1, -1);
    burst(6'd5, 100, 1'b0, 20, -1, -1, -1);
    idle();
    chk("mask_clamped", bus.slot_loaded, {64{1'b1}});
    chk("clamp_last_slot", 64'(bus.blockaddress), 64'd4);

    // Reset in the middle of a 20-word burst.
    burst(6'd0, 20, 1'b0, 0, -1, 10, -1);

    // Clear coinciding with a write to slot 7.
    burst(6'd50, 3, 1'b0, 0, -1, -1, -1);
    burst(6'd7, 1, 1'b0, 0, -1, -1, 0);
    idle();
    bus.clear = 1'b0;
    chk("mask_clear_write", bus.slot_loaded, 64'h80);

    // Randomized bursts.
    for (int k = 0; k < 6; k++) begin
      burst(6'($urandom), int'($urandom_range(0, 70)), 1'b0, int'($urandom_range(0, 60)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1, -1, -1);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_loader.md
# control_loader

Sequencer that loads 16-bit control words into the 64-slot control combiner (64 × 16 = 1024-bit combined control bus). Accepts a burst request (start slot, word count), pulls words from an upstream valid/ready source, and drives the combiner's signal/blockaddress/write port one word per accepted transfer. Sits between the host/config interface and the combiner. Tracks which slots have been loaded since the last clear.

## Interface

Parameters:
- none (slot count 64, word width 16, fixed by the combiner)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  burst request; sampled only in IDLE
- start_addr  in  6  first slot of the burst
- count  in  7  number of words in the burst
- abort  in  1  terminate the current burst
- clear  in  1  clear slot_loaded mask
- in_data  in  16  upstream control word
- in_valid  in  1  upstream word valid
- in_ready  out  1  loader can accept in_data this cycle
- signal  out  16  word to combiner (registered)
- blockaddress  out  6  slot to combiner (registered)
- write  out  1  combiner write strobe, one cycle per word (registered)
- busy  out  1  burst in progress (state == LOAD)
- done  out  1  one-cycle pulse at normal burst completion
- slot_loaded  out  64  bit i set when slot i has been written since last clear/reset

## Operation

- States: IDLE, LOAD.
- IDLE: in_ready=0. On start=1: latch addr=start_addr, remaining=min(count,64).
  - count==0: stay IDLE, done=1 next cycle, no writes.
  - count≥1: go to LOAD.
- LOAD: in_ready = ~abort. Accept = in_valid & in_ready.
  - On accept: next cycle signal=in_data, blockaddress=addr, write=1; addr=addr+1 mod 64 (63 wraps to 0); remaining decrements.
  - Accept with remaining==1: return to IDLE; done=1 in the same cycle the last write is driven.
  - abort=1: return to IDLE next cycle, no accept that cycle, no done; slots already written keep their data and mask bits.
- start while in LOAD is ignored; start and count are not re-sampled.
- count > 64 clamps to 64 (every slot written once, starting at start_addr, wrapping).
- write=0 on any cycle with no accept in the prior cycle; signal/blockaddress hold their last values when write=0.
- slot_loaded: bit blockaddress set on each cycle write=1. clear=1 zeroes the mask; if clear and a write fall in the same cycle, the mask becomes only the bit being written.
- Writes to an already-loaded slot overwrite it (combiner semantics); mask bit stays set.

## Timing

- Reset (async, any state, including mid-burst): state=IDLE, in_ready=0, signal=0, blockaddress=0, write=0, busy=0, done=0, slot_loaded=0, internal addr/remaining=0. Effect immediate on assertion; first action possible on the first rising edge after deassertion.
- start in cycle T → busy=1, in_ready=1 in T+1.
- Accept in cycle T → write=1 with that word in T+1 (latency 1). Throughput 1 word/cycle with in_valid held high.
- N-word burst, continuous valid, start at T: accepts T+1..T+N, writes T+2..T+N+1, done at T+N+1, busy falls at T+N+1, next start accepted at T+N+1.
- in_valid gaps stall the burst without timeout; busy stays 1.
- in_ready is combinational from state and abort only (no dependency on in_valid).
- done and write never asserted in IDLE except the trailing last-word write/done cycle or the count==0 done.

## Test plan

- Reset then start_addr=0, count=64, in_data=i<<2 for i=0..63, valid continuous → 64 writes, blockaddress 0..63 with signal i<<2, done one cycle after the 64th accept, slot_loaded=all ones.
- start_addr=62, count=4, data 0xA000..0xA003 → writes to slots 62,63,0,1; slot_loaded has only bits 62,63,0,1 set.
- count=3 with in_valid toggling 1,0,0,1,0,1 → exactly 3 writes, each one cycle after its accept; busy held through gaps; single done pulse.
- count=8, abort asserted with in_valid=1 after 3 accepts → 3 writes only, no done, busy=0 next cycle; new start accepted the following cycle.
- count=0 → done pulse one cycle after start, no write; count=100 from slot 5 → exactly 64 writes ending at slot 4.
- Reset asserted mid-burst (after 10 of 20 accepts) → all outputs 0 immediately including slot_loaded; start ignored while reset high; clear coinciding with a write to slot 7 → slot_loaded = bit 7 only.
